regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 65 ++++++
 rtl/regfile_writeback.sv | 145 ++++++++++++++
 tb/tb_regfile_writeback.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared sizes and types for the writeback block
package regfile_writeback_pkg;

  localparam int WB_FIFO_DEPTH = 2;
  localparam int REG_W         = 5;
  localparam int DATA_W        = 32;
  localparam int NUM_REGS      = 1 << REG_W;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // One queued ALU write: destination register and its value.
  typedef struct packed {
    reg_idx_t  rd;
    reg_data_t data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small in-order queue exposing every slot for hazard lookup
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH-1:0]       entry_valid,
  output logic [DEPTH*WIDTH-1:0] entries
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] vld;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A per-slot valid bit makes full/empty and the hazard view trivial.
  assign full        = &vld;
  assign empty       = ~|vld;
  assign entry_valid = vld;
  assign head        = mem[rd_ptr];
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign entries[i*WIDTH +: WIDTH] = mem[i];
  end

  // Slot storage, pointers and valid bits; push and pop may share a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= next_ptr(rd_ptr);
      end
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= next_ptr(wr_ptr);
      end
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file write arbiter with load scoreboard and hazard stall
module regfile_writeback
  import regfile_writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  output logic        ld_ready,
  input  logic        ld_rsp_valid,
  input  logic [31:0] ld_rsp_data,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  input  logic [4:0]  q_rd,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd
);

  logic [WB_FIFO_DEPTH*WB_ENTRY_W-1:0] fifo_flat;
  logic [WB_FIFO_DEPTH-1:0]            fifo_vld;
  logic [WB_ENTRY_W-1:0]               head_bits;
  wb_entry_t                           head;
  logic                                fifo_full;
  logic                                fifo_empty;
  logic                                fifo_push;
  logic                                fifo_pop;

  logic [NUM_REGS-1:0] pending;
  logic                ld_busy;
  reg_idx_t            ld_rd;

  logic alu_acc;
  logic alu_keep;
  logic ld_acc;
  logic rsp_acc;
  logic hazard;

  // Handshakes: both ready signals are forced low while reset is held.
  assign alu_ready = !rst && !fifo_full;
  assign ld_ready  = !rst && !ld_busy;
  assign alu_acc   = alu_valid && alu_ready;
  assign alu_keep  = alu_acc && (alu_rd != '0);
  assign ld_acc    = ld_issue && ld_ready;
  assign rsp_acc   = ld_rsp_valid && ld_busy;
  assign head      = head_bits;

  // The queue only holds writes that could not go straight to the port:
  // it is drained whenever the load response does not claim the port, and a
  // new ALU write bypasses it only when nothing is queued ahead of it.
  assign fifo_pop  = !rsp_acc && !fifo_empty;
  assign fifo_push = alu_keep && (rsp_acc || !fifo_empty);

  wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_data   ({alu_rd, alu_data}),
    .pop         (fifo_pop),
    .head        (head_bits),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (fifo_vld),
    .entries     (fifo_flat)
  );

  // A register is busy if a load will write it, a queued ALU write targets
  // it, or it is being written by the port this very cycle.
  function automatic logic reg_hazard(
    input reg_idx_t                            q,
    input logic [NUM_REGS-1:0]                 pend,
    input logic [WB_FIFO_DEPTH*WB_ENTRY_W-1:0] flat,
    input logic [WB_FIFO_DEPTH-1:0]            vld,
    input logic                                we,
    input reg_idx_t                            rd
  );
    wb_entry_t e;
    reg_hazard = 1'b0;
    if (q != '0) begin
      if (pend[q]) reg_hazard = 1'b1;
      if (we && (rd == q)) reg_hazard = 1'b1;
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
        e = flat[i*WB_ENTRY_W +: WB_ENTRY_W];
        if (vld[i] && (e.rd == q)) reg_hazard = 1'b1;
      end
    end
  endfunction

  // Decode-stage hazard lookup across all three queried registers.
  always_comb begin
    hazard = 1'b0;
    if (reg_hazard(q_rs1, pending, fifo_flat, fifo_vld, rf_we, rf_rd)) hazard = 1'b1;
    if (reg_hazard(q_rs2, pending, fifo_flat, fifo_vld, rf_we, rf_rd)) hazard = 1'b1;
    if (reg_hazard(q_rd,  pending, fifo_flat, fifo_vld, rf_we, rf_rd)) hazard = 1'b1;
  end

  // A full queue stalls decode unconditionally, so no ALU result can be lost.
  assign stall = rst || fifo_full || hazard;

  // Load scoreboard and registered write port; load data wins the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ld_busy <= 1'b0;
      ld_rd   <= '0;
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_wd   <= '0;
    end else begin
      rf_we <= 1'b0;
      if (ld_acc) begin
        ld_busy <= 1'b1;
        ld_rd   <= ld_issue_rd;
        if (ld_issue_rd != '0) pending[ld_issue_rd] <= 1'b1;
      end
      if (rsp_acc) begin
        ld_busy        <= 1'b0;
        pending[ld_rd] <= 1'b0;
        // A load to x0 completes the handshake but never reaches the port.
        if (ld_rd != '0) begin
          rf_we <= 1'b1;
          rf_rd <= ld_rd;
          rf_wd <= ld_rsp_data;
        end
      end else if (!fifo_empty) begin
        rf_we <= 1'b1;
        rf_rd <= head.rd;
        rf_wd <= head.data;
      end else if (alu_keep) begin
        rf_we <= 1'b1;
        rf_rd <= alu_rd;
        rf_wd <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_ready;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_data;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .ld_issue     (ld_issue),
    .ld_issue_rd  (ld_issue_rd),
    .ld_ready     (ld_ready),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_data  (ld_rsp_data),
    .q_rs1        (q_rs1),
    .q_rs2        (q_rs2),
    .q_rd         (q_rd),
    .stall        (stall),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wd        (rf_wd)
  );

  // Reference model: a queue of waiting writes, one outstanding load, and
  // the value currently on the write port.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         mq[$];
  bit          m_busy;
  logic [4:0]  m_dst;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  function automatic void model_reset();
    mq.delete();
    m_busy = 0;
    m_dst  = '0;
    m_we   = 0;
    m_rd   = '0;
    m_wd   = '0;
  endfunction

  function automatic bit m_alu_ready();
    return (rst === 1'b0) && (mq.size() < 2);
  endfunction

  function automatic bit m_ld_ready();
    return (rst === 1'b0) && !m_busy;
  endfunction

  function automatic bit m_reg_busy(input logic [4:0] r);
    if (r == 0) return 0;
    if (m_busy && m_dst == r) return 1;
    foreach (mq[i]) if (mq[i].rd == r) return 1;
    if (m_we && m_rd == r) return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    return (rst === 1'b1) || (mq.size() == 2) ||
           m_reg_busy(q_rs1) || m_reg_busy(q_rs2) || m_reg_busy(q_rd);
  endfunction

  function automatic void model_edge();
    bit  acc;
    bit  was_busy;
    wr_t e;
    wr_t h;
    if (rst === 1'b1) begin
      model_reset();
      return;
    end
    acc      = alu_valid && (mq.size() < 2) && (alu_rd != 0);
    was_busy = m_busy;
    e.rd     = alu_rd;
    e.data   = alu_data;
    m_we     = 0;
    if (ld_rsp_valid && was_busy) begin
      m_busy = 0;
      if (m_dst != 0) begin
        m_we = 1; m_rd = m_dst; m_wd = ld_rsp_data;
      end
      if (acc) mq.push_back(e);
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_we = 1; m_rd = h.rd; m_wd = h.data;
      if (acc) mq.push_back(e);
    end else if (acc) begin
      m_we = 1; m_rd = alu_rd; m_wd = alu_data;
    end
    if (ld_issue && !was_busy) begin
      m_busy = 1;
      m_dst  = ld_issue_rd;
    end
  endfunction

  task automatic drive_idle();
    alu_valid    = 0;
    alu_rd       = '0;
    alu_data     = '0;
    ld_issue     = 0;
    ld_issue_rd  = '0;
    ld_rsp_valid = 0;
    ld_rsp_data  = '0;
    q_rs1        = '0;
    q_rs2        = '0;
    q_rd         = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive_idle();
    model_reset();
    #1;
    n_checks++;
    if (alu_ready !== 1'b0 || ld_ready !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: alu_ready=%b ld_ready=%b stall=%b, required 0 0 1", alu_ready, ld_ready, stall);
    end
    n_checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_port: we=%b rd=%0d wd=%h, required 0 0 0", rf_we, rf_rd, rf_wd);
    end
    tick();
    tick();
    rst = 0;
    model_reset();
    #1;
    n_checks++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: alu_ready=%b ld_ready=%b stall=%b, required 1 1 0", alu_ready, ld_ready, stall);
    end
  endtask

  task automatic test_alu_write();
    drive_idle();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_ready_idle: got %b required 1", alu_ready);
    end
    tick();
    drive_idle();
    n_checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL alu_write: we=%b rd=%0d wd=%h, required 1 5 12345678", rf_we, rf_rd, rf_wd);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wd !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL alu_one_cycle: we=%b rd=%0d wd=%h, required 0 with rd/wd held", rf_we, rf_rd, rf_wd);
    end
  endtask

  task automatic test_load_hazard();
    drive_idle();
    ld_issue = 1; ld_issue_rd = 7;
    #1;
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_ready_idle: got %b required 1", ld_ready);
    end
    tick();
    drive_idle();
    q_rs1 = 7;
    #1;
    n_checks++;
    if (stall !== 1'b1 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_pending: stall=%b ld_ready=%b, required 1 0", stall, ld_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (stall !== 1'b1 || rf_we !== 1'b0) begin
        n_fail++;
        $display("FAIL load_wait%0d: stall=%b we=%b, required 1 0", i, stall, rf_we);
      end
    end
    ld_rsp_valid = 1; ld_rsp_data = 32'hDEAD_BEEF;
    tick();
    ld_rsp_valid = 0;
    #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_write: we=%b rd=%0d wd=%h, required 1 7 deadbeef", rf_we, rf_rd, rf_wd);
    end
    n_checks++;
    if (stall !== 1'b1 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_write_stall: stall=%b ld_ready=%b, required 1 1", stall, ld_ready);
    end
    tick();
    n_checks++;
    if (stall !== 1'b0 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL load_release: stall=%b we=%b, required 0 0", stall, rf_we);
    end
    drive_idle();
  endtask

  task automatic test_collision();
    drive_idle();
    ld_issue = 1; ld_issue_rd = 9;
    tick();
    drive_idle();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h1;
    ld_rsp_valid = 1; ld_rsp_data = 32'hAA;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_ready: got %b required 1", alu_ready);
    end
    tick();
    drive_idle();
    n_checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wd !== 32'hAA) begin
      n_fail++;
      $display("FAIL collide_first: we=%b rd=%0d wd=%h, required 1 9 aa", rf_we, rf_rd, rf_wd);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 32'h1) begin
      n_fail++;
      $display("FAIL collide_second: we=%b rd=%0d wd=%h, required 1 3 1", rf_we, rf_rd, rf_wd);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_idle: we=%b required 0", rf_we);
    end
  endtask

  task automatic test_fifo_full();
    logic [4:0]  exp_rd [6];
    logic [31:0] exp_wd [6];
    wr_t         log_q[$];
    wr_t         w;
    exp_rd = '{5'd20, 5'd10, 5'd21, 5'd11, 5'd12, 5'd13};
    exp_wd = '{32'hA014, 32'h100, 32'hA015, 32'h101, 32'h102, 32'h103};
    drive_idle();
    ld_issue = 1; ld_issue_rd = 20;
    tick();
    for (int c = 0; c < 7; c++) begin
      drive_idle();
      if (c < 3) begin
        alu_valid = 1; alu_rd = 5'(10 + c); alu_data = 32'(32'h100 + c);
      end else if (c < 5) begin
        alu_valid = 1; alu_rd = 5'd13; alu_data = 32'h103;
      end
      if (c == 0 || c == 2) begin
        ld_rsp_valid = 1; ld_rsp_data = (c == 0) ? 32'hA014 : 32'hA015;
      end
      if (c == 1) begin
        ld_issue = 1; ld_issue_rd = 21;
      end
      #1;
      if (c == 3) begin
        n_checks++;
        if (alu_ready !== 1'b0 || stall !== 1'b1) begin
          n_fail++;
          $display("FAIL full_block: alu_ready=%b stall=%b, required 0 1", alu_ready, stall);
        end
      end else if (c < 5) begin
        n_checks++;
        if (alu_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_ready%0d: alu_ready=%b required 1", c, alu_ready);
        end
      end
      tick();
      if (rf_we === 1'b1) begin
        w.rd = rf_rd; w.data = rf_wd;
        log_q.push_back(w);
      end
    end
    drive_idle();
    n_checks++;
    if (log_q.size() != 6) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes required 6", log_q.size());
    end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i].rd !== exp_rd[i] || log_q[i].data !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL full_order%0d: rd=%0d wd=%h, required rd=%0d wd=%h", i, log_q[i].rd, log_q[i].data, exp_rd[i], exp_wd[i]);
      end
    end
  endtask

  task automatic test_rd0();
    drive_idle();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
    ld_issue = 1; ld_issue_rd = 0;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd0_accept: alu_ready=%b ld_ready=%b, required 1 1", alu_ready, ld_ready);
    end
    tick();
    drive_idle();
    n_checks++;
    if (rf_we !== 1'b0 || ld_ready !== 1'b0 || dut.pending !== 32'd0) begin
      n_fail++;
      $display("FAIL rd0_issue: we=%b ld_ready=%b pending=%h, required 0 0 0", rf_we, ld_ready, dut.pending);
    end
    ld_rsp_valid = 1; ld_rsp_data = 32'h55;
    tick();
    drive_idle();
    n_checks++;
    if (rf_we !== 1'b0 || ld_ready !== 1'b1 || dut.pending !== 32'd0) begin
      n_fail++;
      $display("FAIL rd0_rsp: we=%b ld_ready=%b pending=%h, required 0 1 0", rf_we, ld_ready, dut.pending);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_after: we=%b required 0", rf_we);
    end
  endtask

  task automatic test_reset_midload();
    drive_idle();
    ld_issue = 1; ld_issue_rd = 22;
    tick();
    drive_idle();
    ld_rsp_valid = 1; ld_rsp_data = 32'h300;
    alu_valid = 1; alu_rd = 15; alu_data = 32'h200;
    tick();
    drive_idle();
    ld_issue = 1; ld_issue_rd = 23;
    alu_valid = 1; alu_rd = 16; alu_data = 32'h201;
    tick();
    drive_idle();
    ld_rsp_valid = 1; ld_rsp_data = 32'h301;
    alu_valid = 1; alu_rd = 17; alu_data = 32'h202;
    tick();
    drive_idle();
    ld_issue = 1; ld_issue_rd = 24;
    #1;
    n_checks++;
    if (alu_ready !== 1'b0 || rf_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midload_setup: alu_ready=%b we=%b, required 0 1", alu_ready, rf_we);
    end
    rst = 1;
    model_reset();
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'd0 ||
        alu_ready !== 1'b0 || ld_ready !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL midload_reset: we=%b rd=%0d wd=%h ar=%b lr=%b st=%b, required 0 0 0 0 0 1",
               rf_we, rf_rd, rf_wd, alu_ready, ld_ready, stall);
    end
    drive_idle();
    tick();
    rst = 0;
    model_reset();
    ld_rsp_valid = 1; ld_rsp_data = 32'h77;
    #1;
    n_checks++;
    if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midload_release: ld_ready=%b alu_ready=%b, required 1 1", ld_ready, alu_ready);
    end
    tick();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rf_we !== 1'b0) begin
        n_fail++;
        $display("FAIL midload_nowrite%0d: we=%b rd=%0d, required we 0", i, rf_we, rf_rd);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_valid    = 1'($urandom_range(0, 1));
      alu_rd       = 5'($urandom_range(0, 7));
      alu_data     = $urandom;
      ld_issue     = ($urandom_range(0, 3) == 0);
      ld_issue_rd  = 5'($urandom_range(0, 7));
      ld_rsp_valid = ($urandom_range(0, 2) == 0);
      ld_rsp_data  = $urandom;
      q_rs1        = 5'($urandom_range(0, 7));
      q_rs2        = 5'($urandom_range(0, 7));
      q_rd         = 5'($urandom_range(0, 7));
      #1;
      n_checks++;
      if (alu_ready !== m_alu_ready() || ld_ready !== m_ld_ready() || stall !== m_stall()) begin
        n_fail++;
        $display("FAIL rand_ctrl%0d: ar=%b lr=%b st=%b, required %b %b %b",
                 i, alu_ready, ld_ready, stall, m_alu_ready(), m_ld_ready(), m_stall());
      end
      tick();
      n_checks++;
      if (rf_we !== m_we || rf_rd !== m_rd || rf_wd !== m_wd) begin
        n_fail++;
        $display("FAIL rand_port%0d: we=%b rd=%0d wd=%h, required %b %0d %h",
                 i, rf_we, rf_rd, rf_wd, m_we, m_rd, m_wd);
      end
      n_checks++;
      if (rf_we === 1'b1 && rf_rd === 5'd0) begin
        n_fail++;
        $display("FAIL rand_x0_%0d: we=%b rd=%0d, required no write to x0", i, rf_we, rf_rd);
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_hazard();
    test_collision();
    test_fifo_full();
    test_rd0();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
